fp_div_arbiter: RTL and testbench
=================================

Name: fp_div_arbiter

Overview:
- Shares one combinational single-precision divider among NUM_REQ requesters, e.g. per-body force units that need 1/r or a/m.
- Arbitrates round-robin and registers the operands into the divider.
- Holds the operands stable for DIV_LATENCY cycles, since the divider path is multicycle-constrained, then captures the quotient.
- Returns the quotient to the winning requester with a valid/ready handshake.

Parameters:
- NUM_REQ, 4: number of requesters; must be ≥2.
- DIV_LATENCY, 2: cycles operands are held before div_q is sampled; must be ≥1.
- ID_W, $clog2(NUM_REQ): width of the requester index (localparam).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot; high only for the granted requester while idle.
- req_a  in  NUM_REQ*32  dividends; requester i uses bits [32i+31:32i].
- req_b  in  NUM_REQ*32  divisors; same packing as req_a.
- resp_valid  out  NUM_REQ  one-hot; the quotient is ready for that requester.
- resp_ready  in  NUM_REQ  per-requester acceptance of the response.
- resp_data  out  32  quotient; valid only while resp_valid is non-zero.
- div_a  out  32  registered dividend to the divider.
- div_b  out  32  registered divisor to the divider.
- div_q  in  32  divider result.
- busy  out  1  state ≠ IDLE.
- op_count  out  16  completed operations; wraps at 0xFFFF→0.

Behaviour:
- Reset (async, while rst_n=0) clears:
  - state=IDLE, rr_ptr=NUM_REQ-1, cnt=0, owner=0;
  - div_a=div_b=0, resp_data=0, resp_valid=0, op_count=0.
  - Combinational outputs therefore read req_ready=0 and busy=0 during reset.
- An in-flight operation is discarded on reset; no response is ever issued for it.
- Grant (combinational, IDLE only): the first index with req_valid=1, scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ. req_ready is one-hot at that index, or 0 if no request. In other states req_ready=0.
- A requester must hold req_valid, req_a and req_b stable until it sees req_ready. Dropping req_valid early is allowed: that requester simply gets no grant.
- IDLE: on an accept at edge T (req_valid[g]&req_ready[g]):
  - div_a←req_a[g], div_b←req_b[g], owner←g;
  - cnt←DIV_LATENCY-1;
  - state←WAIT.
- WAIT: div_a and div_b are held constant.
  - If cnt≠0: cnt←cnt-1.
  - If cnt==0: resp_data←div_q, resp_valid←one-hot(owner), op_count←op_count+1, state←RESP.
  - So resp_valid rises DIV_LATENCY edges after the accept.
- RESP: resp_valid and resp_data are held until resp_ready[owner]=1. At that edge: resp_valid←0, rr_ptr←owner, state←IDLE.
- resp_ready bits for non-owners are ignored.
- Throughput: at most one operation per DIV_LATENCY+2 cycles. A new grant is never issued in the same cycle a response completes.
- Fairness: after completing index k, index k has the lowest priority. With all NUM_REQ requesters continuously valid, grants rotate 0,1,2,…,NUM_REQ-1,0,…
- Divider outputs are passed through unchanged; special values (NaN, ±inf, 0) are not reinterpreted.
- Unknown or illegal state encoding: state←IDLE.

Decomposition:
- Package fp_div_pkg:
  - state enum {IDLE, WAIT, RESP} (2 bits);
  - FP32_W=32 and the constants FP_PINF=32'h7F800000, FP_NINF=32'hFF800000, FP_ZERO=32'h0 (shared with the benches).
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr[ID_W]; outputs gnt one-hot[N], gnt_idx[ID_W], any.
- The divider itself is instantiated one level up and wired to div_a, div_b and div_q.

Test Plan:
- Single op, DIV_LATENCY=2, requester 1:
  - Stimulus: req_a=0x40C00000 (6.0), req_b=0x40000000 (2.0).
  - Required: accept at T; resp_valid=4'b0010 and resp_data=0x40400000 after edge T+2; op_count=1.
- All 4 requesters valid, resp_ready tied high, operands a_i=0x41200000 (10.0), b_i=0x40000000 (2.0):
  - Required: grant order 0,1,2,3,0; every response is 0x40A00000; one accept every 4 cycles.
- Backpressure: hold resp_ready[2]=0 for 10 cycles.
  - Required: resp_valid[2] and resp_data stay constant, req_ready=0 throughout; completion on the first cycle resp_ready[2]=1.
- Special values:
  - 0x3F800000 / 0x00000000 → 0x7F800000;
  - 0x00000000 / 0x00000000 → 0x7FFFFFF0 (NaN).
  - Both are passed through unchanged.
- Reset mid-WAIT: assert rst_n=0 one cycle after an accept.
  - Required: all outputs return to reset values immediately, no resp_valid afterwards, op_count=0.
  - Next request after reset is granted to index 0.
- op_count wrap: preload via 65536 back-to-back operations (or force) → op_count reads 0x0000.

Source files
------------

// File: rtl/fp_div_pkg.sv
// ---------------------------------------------------------------------------
// fp_div_pkg
// Shared types and constants for the shared-divider arbiter and its benches.
//   state_t  : arbiter FSM states (IDLE, WAIT, RESP), 2-bit encoding
//   FP32_W   : width of an IEEE-754 single-precision word
//   FP_PINF, FP_NINF, FP_ZERO : common special-value encodings
// ---------------------------------------------------------------------------
package fp_div_pkg;

  localparam int FP32_W = 32;

  localparam logic [FP32_W-1:0] FP_PINF = 32'h7F80_0000;
  localparam logic [FP32_W-1:0] FP_NINF = 32'hFF80_0000;
  localparam logic [FP32_W-1:0] FP_ZERO = 32'h0000_0000;

  // IDLE waits for a request, WAIT holds operands while the multicycle
  // divider path settles, RESP holds the quotient until the owner takes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker.
//   req     in  N     request vector
//   ptr     in  ID_W  index that won last; it gets the lowest priority
//   gnt     out N     one-hot grant (all zero when no request)
//   gnt_idx out ID_W  binary index of the grant (0 when no request)
//   any     out 1     at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  int idx;

  // Scan ptr+1, ptr+2, ... wrapping modulo N; the first asserted request
  // wins. Because ptr itself is visited last, the previous winner always
  // drops to the bottom of the priority order.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[ID_W'(idx)]) begin
        gnt[ID_W'(idx)] = 1'b1;
        gnt_idx         = ID_W'(idx);
        any             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_div_arbiter.sv
// ---------------------------------------------------------------------------
// fp_div_arbiter
// Shares one combinational FP32 divider (instantiated by the parent) among
// NUM_REQ requesters. Round-robin grant, registered operands held for
// DIV_LATENCY cycles, captured quotient returned with valid/ready.
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready per-requester request handshake (ready one-hot)
//   req_a, req_b        packed dividends/divisors, 32 bits per requester
//   resp_valid          one-hot: quotient available for that requester
//   resp_ready          per-requester acceptance (only the owner's bit counts)
//   resp_data           captured quotient
//   div_a, div_b, div_q registered operands to / result from the divider
//   busy                high whenever the FSM is not IDLE
//   op_count            completed operations, wraps at 16 bits
// ---------------------------------------------------------------------------
module fp_div_arbiter
  import fp_div_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DIV_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FP32_W-1:0] req_a,
  input  logic [NUM_REQ*FP32_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [FP32_W-1:0]         resp_data,
  output logic [FP32_W-1:0]         div_a,
  output logic [FP32_W-1:0]         div_b,
  input  logic [FP32_W-1:0]         div_q,
  output logic                      busy,
  output logic [15:0]               op_count
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

  state_t            state_q;
  state_t            state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   owner_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       op_cnt_q;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;

  logic accept;
  logic cnt_zero;
  logic finish_wait;
  logic resp_done;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Grants are only offered while idle; rst_n also gates them so that no
  // requester sees ready while the block is held in reset.
  assign req_ready   = (state_q == IDLE && rst_n) ? gnt : '0;
  assign busy        = (state_q != IDLE);
  assign op_count    = op_cnt_q;

  assign accept      = (state_q == IDLE) && gnt_any;
  assign cnt_zero    = (cnt_q == '0);
  assign finish_wait = (state_q == WAIT) && cnt_zero;
  assign resp_done   = (state_q == RESP) && resp_ready[owner_q];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The RESP->IDLE step always costs a cycle, so a new
  // grant can never coincide with a response completing. Any encoding
  // outside the enum falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = WAIT;
      WAIT:    if (cnt_zero)  state_d = RESP;
      RESP:    if (resp_done) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Operand capture and latency countdown. div_a/div_b are only written on
  // an accept, so they stay frozen through WAIT and RESP as the multicycle
  // path through the divider requires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_a   <= '0;
      div_b   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      div_a   <= req_a[FP32_W*gnt_idx +: FP32_W];
      div_b   <= req_b[FP32_W*gnt_idx +: FP32_W];
      owner_q <= gnt_idx;
      cnt_q   <= CNT_W'(DIV_LATENCY - 1);
    end else if (state_q == WAIT && !cnt_zero) begin
      cnt_q   <= cnt_q - 1'b1;
    end
  end

  // Response side: sample the divider once the latency has elapsed, hold it
  // until the owner accepts, then make the owner the lowest-priority index
  // for the next arbitration round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data  <= '0;
      resp_valid <= '0;
      op_cnt_q   <= '0;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
    end else begin
      if (finish_wait) begin
        resp_data  <= div_q;
        resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
        op_cnt_q   <= op_cnt_q + 16'd1;
      end
      if (resp_done) begin
        resp_valid <= '0;
        rr_ptr_q   <= owner_q;
      end
    end
  end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_div_arbiter
// Directed bench for fp_div_arbiter with a lookup-table stand-in for the
// shared divider and a queue-based scoreboard of expected responses.
// ---------------------------------------------------------------------------
module tb_fp_div_arbiter;
  import fp_div_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int DIV_LATENCY = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   resp_valid;
  logic [3:0]   resp_ready;
  logic [31:0]  resp_data;
  logic [31:0]  div_a;
  logic [31:0]  div_b;
  logic [31:0]  div_q;
  logic         busy;
  logic [15:0]  op_count;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  int          accept_cycle[$];
  logic [31:0] exp_q [4];
  int          cycle;
  int          n_checks;
  int          n_pass;

  always #5 clk = ~clk;

  fp_div_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DIV_LATENCY (DIV_LATENCY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_q      (div_q),
    .busy       (busy),
    .op_count   (op_count)
  );

  // Stand-in for the shared combinational divider: known operand pairs only.
  function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40C0_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'h4120_0000, 32'h4000_0000}: return 32'h40A0_0000;
      {32'h3F80_0000, FP_ZERO}:       return FP_PINF;
      {FP_ZERO, FP_ZERO}:             return 32'h7FFF_FFF0;
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h3F80_0000;
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign div_q = div_model(div_a, div_b);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
    req_valid[idx]        = 1'b1;
    req_a[idx*32 +: 32]   = a;
    req_b[idx*32 +: 32]   = b;
    exp_q[idx]            = q;
  endtask

  // One clock: record accepts and check completions at the falling edge,
  // then return 1ns after the rising edge so the caller can drive inputs.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{id: 2'(i), data: exp_q[i]});
          grant_log.push_back(i);
          accept_cycle.push_back(cycle);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_resp", 32'(resp_valid), 32'h0);
          end else begin
            e = sb.pop_front();
            checkOutput("resp_owner", 32'(resp_valid), 32'(4'b0001 << e.id));
            checkOutput("resp_data", resp_data, e.data);
          end
        end
      end
    end
    @(posedge clk);
    cycle++;
    #1;
  endtask

  task automatic resetDut();
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    sb.delete();
    grant_log.delete();
    accept_cycle.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic runOp(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
    applyStimulus(idx, a, b, q);
    resp_ready = '1;
    tick();
    req_valid[idx] = 1'b0;
    checkOutput("op_accepted", 32'(sb.size()), 32'd1);
    for (int n = 0; n < 10 && sb.size() != 0; n++) tick();
    checkOutput("op_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int          exp_order [5];
    logic [3:0]  seen;
    exp_order = '{0, 1, 2, 3, 0};
    n_checks  = 0;
    n_pass    = 0;
    cycle     = 0;
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    resp_ready = '0;
    for (int i = 0; i < 4; i++) exp_q[i] = '0;

    // Reset values, with every requester asking so ready gating is visible.
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_op_count", 32'(op_count), 32'h0);
    checkOutput("rst_div_a", div_a, 32'h0);
    checkOutput("rst_div_b", div_b, 32'h0);
    checkOutput("rst_resp_data", resp_data, 32'h0);
    resetDut();

    // Single operation from requester 1: 6.0 / 2.0.
    applyStimulus(1, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
    #1;
    checkOutput("single_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    checkOutput("single_busy", 32'(busy), 32'h1);
    checkOutput("single_div_a", div_a, 32'h40C0_0000);
    checkOutput("single_div_b", div_b, 32'h4000_0000);
    checkOutput("single_valid_t1", 32'(resp_valid), 32'h0);
    tick();
    checkOutput("single_valid_t2early", 32'(resp_valid), 32'h0);
    tick();
    checkOutput("single_valid_t2", 32'(resp_valid), 32'h2);
    checkOutput("single_data", resp_data, 32'h4040_0000);
    checkOutput("single_op_count", 32'(op_count), 32'h1);
    resp_ready = '1;
    tick();
    checkOutput("single_idle", 32'(busy), 32'h0);
    checkOutput("single_valid_clr", 32'(resp_valid), 32'h0);

    // All four requesters continuously valid with responses always accepted.
    resetDut();
    for (int i = 0; i < 4; i++) applyStimulus(i, 32'h4120_0000, 32'h4000_0000, 32'h40A0_0000);
    resp_ready = '1;
    repeat (20) tick();
    req_valid = '0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++)
      checkOutput("rr_grant_order", 32'((i < grant_log.size()) ? grant_log[i] : -1), 32'(exp_order[i]));
    for (int i = 1; i < 5; i++)
      checkOutput("rr_accept_gap",
                  32'((i < accept_cycle.size()) ? accept_cycle[i] - accept_cycle[i-1] : -1), 32'd4);
    checkOutput("rr_drained", 32'(sb.size()), 32'd0);
    checkOutput("rr_op_count", 32'(op_count), 32'd5);

    // Backpressure on requester 2; non-owner ready bits and pending requests
    // from the others must not disturb the held response.
    resp_ready = '0;
    applyStimulus(2, 32'h4120_0000, 32'h4000_0000, 32'h40A0_0000);
    tick();
    req_valid[2] = 1'b0;
    for (int i = 0; i < 4; i++)
      if (i != 2) applyStimulus(i, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    resp_ready = 4'b1011;
    tick();
    tick();
    for (int n = 0; n < 10; n++) begin
      checkOutput("bp_resp_valid", 32'(resp_valid), 32'h4);
      checkOutput("bp_resp_data", resp_data, 32'h40A0_0000);
      checkOutput("bp_req_ready", 32'(req_ready), 32'h0);
      tick();
    end
    req_valid  = '0;
    resp_ready = 4'b0100;
    tick();
    checkOutput("bp_released", 32'(resp_valid), 32'h0);
    checkOutput("bp_idle", 32'(busy), 32'h0);
    checkOutput("bp_op_count", 32'(op_count), 32'd6);

    // Special values pass through untouched.
    runOp(3, 32'h3F80_0000, FP_ZERO, FP_PINF);
    runOp(0, FP_ZERO, FP_ZERO, 32'h7FFF_FFF0);
    checkOutput("special_op_count", 32'(op_count), 32'd8);

    // Reset while an operation is in flight.
    applyStimulus(1, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
    resp_ready = '1;
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("midrst_op_count", 32'(op_count), 32'h0);
    checkOutput("midrst_div_a", div_a, 32'h0);
    checkOutput("midrst_resp_data", resp_data, 32'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen  = '0;
    for (int n = 0; n < 6; n++) begin
      seen |= resp_valid;
      tick();
    end
    checkOutput("midrst_no_resp", 32'(seen), 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(i, 32'h4120_0000, 32'h4000_0000, 32'h40A0_0000);
    #1;
    checkOutput("midrst_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    for (int n = 0; n < 10 && sb.size() != 0; n++) tick();
    checkOutput("midrst_drained", 32'(sb.size()), 32'd0);
    checkOutput("midrst_op_count_after", 32'(op_count), 32'd1);

    // Counter wrap: preload the counter to its maximum, then complete one op.
    force dut.op_cnt_q = 16'hFFFF;
    #1;
    release dut.op_cnt_q;
    #1;
    checkOutput("wrap_preload", 32'(op_count), 32'h0000_FFFF);
    runOp(2, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    checkOutput("wrap_op_count", 32'(op_count), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a hung handshake.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
